// File: rtl/uart_pkt_xcvr_pkg.sv
// rtl/uart_pkt_xcvr_pkg.sv - shared types, constants and width helper for the packet UART
// Purpose: receiver/transmitter state enums, character length and the counter
// width function used by uart_pkt_xcvr and uart_tx_ser. No ports.
package uart_pkt_pkg;

  localparam int BITS_PER_CHAR = 10;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_pkt_xcvr_if.sv
// rtl/uart_pkt_xcvr_if.sv - frame/response handshake bundle between host logic and the packet UART
// Purpose: groups the frame-ready and response-send handshakes.
// Signals:
//   frm_data[8*RX_BYTES] / frm_rdy / rx_err / rx_ovr : receive side, driven by the UART
//   clr_frm_rdy                                      : host acknowledge of frm_rdy
//   rsp_data[8*TX_BYTES] / snd_rsp                   : response request, driven by the host
//   tx_busy / tx_done                                : transmit status, driven by the UART
// Modports: master = host side, slave = UART side.
interface uart_pkt_xcvr_if #(
  parameter int RX_BYTES = 3,
  parameter int TX_BYTES = 2
);
  logic [8*RX_BYTES-1:0] frm_data;
  logic                  frm_rdy;
  logic                  clr_frm_rdy;
  logic                  rx_err;
  logic                  rx_ovr;
  logic [8*TX_BYTES-1:0] rsp_data;
  logic                  snd_rsp;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    input  frm_data, frm_rdy, rx_err, rx_ovr, tx_busy, tx_done,
    output clr_frm_rdy, rsp_data, snd_rsp
  );

  modport slave (
    output frm_data, frm_rdy, rx_err, rx_ovr, tx_busy, tx_done,
    input  clr_frm_rdy, rsp_data, snd_rsp
  );
endinterface

// File: rtl/uart_pkt_xcvr_tx_ser.sv
// rtl/uart_pkt_xcvr_tx_ser.sv - multi-byte response serialiser (start, 8 data LSB first, stop)
// Purpose: latches a TX_BYTES-byte word on i_load while idle and shifts it out
// MSB byte first, back-to-back characters, each bit CLK_DIV cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : send request, honoured only while idle
//   i_data     : response word, sampled in the accept cycle only
//   o_tx       : serial line, idle high
//   o_busy     : high from the cycle after accept until the last stop bit ends
//   o_done     : one-cycle pulse in the cycle after the last stop bit
module uart_tx_ser
  import uart_pkt_pkg::*;
#(
  parameter int CLK_DIV  = 868,
  parameter int TX_BYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [8*TX_BYTES-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int W      = 8 * TX_BYTES;
  localparam int BAUD_W = cnt_w(CLK_DIV - 1);
  localparam int LEFT_W = cnt_w(TX_BYTES);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [LEFT_W-1:0] LEFT_ALL  = LEFT_W'(TX_BYTES);
  localparam logic [LEFT_W-1:0] LEFT_ONE  = LEFT_W'(1);

  tx_state_t         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_byte;   // remaining data bits of the character on the line
  logic [W-1:0]      r_shift;  // characters not yet started, next one in the MSBs
  logic [LEFT_W-1:0] r_left;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_left  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (i_load) begin
            r_shift <= i_data;
            r_left  <= LEFT_ALL;
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[W-8];
            r_byte  <= {1'b0, r_shift[W-1 -: 7]};
            r_shift <= r_shift << 8;
            r_state <= TX_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_tx   <= r_byte[0];
              r_byte <= r_byte >> 1;
              r_bit  <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_left == LEFT_ONE) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= TX_IDLE;
            end else begin
              r_left  <= r_left - 1'b1;
              r_tx    <= 1'b0;
              r_state <= TX_START;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule

// File: rtl/uart_pkt_xcvr.sv
// rtl/uart_pkt_xcvr.sv - full-duplex packet UART: framed receiver with handshake plus response transmitter
// Purpose: assembles RX_BYTES-byte frames from i_rx (first byte in the MSBs),
// reports framing errors, inter-byte timeouts and overruns, and sends
// TX_BYTES-byte responses through uart_tx_ser.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_rx       : serial input, idle high, asynchronous to clk
//   o_tx       : serial output, idle high
//   bus        : uart_pkt_xcvr_if.slave frame/response handshake
module uart_pkt_xcvr
  import uart_pkt_pkg::*;
#(
  parameter int CLK_DIV  = 868,
  parameter int RX_BYTES = 3,
  parameter int TX_BYTES = 2,
  parameter int TO_BITS  = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_rx,
  output logic            o_tx,
  uart_pkt_xcvr_if.slave  bus
);
  localparam int FRM_W  = 8 * RX_BYTES;
  localparam int BAUD_W = cnt_w(CLK_DIV - 1);
  localparam int CNT_W  = cnt_w(RX_BYTES);
  localparam int TO_W   = cnt_w(TO_BITS * CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RX_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_BITS * CLK_DIV - 1);

  logic              r_rx_s1;
  logic              r_rx_s2;
  rx_state_t         r_rx_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_rx_byte;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [FRM_W-1:0]  r_asm;
  logic [FRM_W-1:0]  r_frm_data;
  logic              r_frm_rdy;
  logic              r_rx_err;
  logic              r_rx_ovr;
  logic [FRM_W-1:0]  w_asm_next;
  logic              w_tx_busy;
  logic              w_tx_done;

  assign w_asm_next = (r_asm << 8) | FRM_W'(r_rx_byte);

  // Two-flop synchroniser, preset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_rx_byte  <= '0;
      r_rx_cnt   <= '0;
      r_to_cnt   <= '0;
      r_asm      <= '0;
      r_frm_data <= '0;
      r_frm_rdy  <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rx_err <= 1'b0;
      r_rx_ovr <= 1'b0;
      if (bus.clr_frm_rdy) r_frm_rdy <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_baud <= '0;
          if (!r_rx_s2) begin
            r_to_cnt   <= '0;
            r_rx_state <= RX_START;
          end else if (r_rx_cnt != '0) begin
            // Partial frame on an idle line: drop it once the gap is too long.
            if (r_to_cnt == TO_LAST) begin
              r_to_cnt <= '0;
              r_rx_cnt <= '0;
              r_rx_err <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end else begin
            r_to_cnt <= '0;
          end
        end
        RX_START: begin
          if (r_baud == HALF_LAST) begin
            r_baud     <= '0;
            r_bit      <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud    <= '0;
            r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
            r_bit     <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud     <= '0;
            r_rx_state <= RX_IDLE;
            if (!r_rx_s2) begin
              r_rx_cnt <= '0;
              r_rx_err <= 1'b1;
            end else if (r_rx_cnt == CNT_LAST) begin
              r_rx_cnt   <= '0;
              r_asm      <= w_asm_next;
              r_frm_data <= w_asm_next;
              // Completion overrides a same-cycle clear; that clear also means no overrun.
              r_frm_rdy  <= 1'b1;
              r_rx_ovr   <= r_frm_rdy & ~bus.clr_frm_rdy;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
              r_asm    <= w_asm_next;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_tx_ser #(
    .CLK_DIV  (CLK_DIV),
    .TX_BYTES (TX_BYTES)
  ) u_tx_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (bus.snd_rsp),
    .i_data (bus.rsp_data),
    .o_tx   (o_tx),
    .o_busy (w_tx_busy),
    .o_done (w_tx_done)
  );

  assign bus.frm_data = r_frm_data;
  assign bus.frm_rdy  = r_frm_rdy;
  assign bus.rx_err   = r_rx_err;
  assign bus.rx_ovr   = r_rx_ovr;
  assign bus.tx_busy  = w_tx_busy;
  assign bus.tx_done  = w_tx_done;
endmodule
